store_formatter: RTL and testbench
==================================

STORE_FORMATTER -- requirements
Module: store_formatter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 st_valid  input  1  store request from CPU datapath.
REQ-004 st_ready  output  1  block accepts a request this cycle; high only in IDLE.
REQ-005 st_addr  input  32  byte address of store.
REQ-006 st_data  input  32  register value; the low 8/16/32 bits are stored per size.
REQ-007 st_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 mem_req  output  1  bus beat valid; held until mem_ack.
REQ-009 mem_addr  output  32  word-aligned beat address; bits [1:0] always 00.
REQ-010 mem_wdata  output  32  lane-positioned write data; disabled lanes driven 0.
REQ-011 mem_be  output  4  byte enables; bit i = lane i = bits [8i+7:8i], little-endian.
REQ-012 mem_ack  input  1  memory accepted current beat.
REQ-013 done  output  1  one-cycle pulse; store fully written.
REQ-014 err  output  1  one-cycle pulse; illegal size rejected.

Function
REQ-015 Acceptance SHALL occur on a rising edge with st_valid=1 and st_ready=1; addr, data and size SHALL be captured at that edge.
REQ-016 States SHALL be IDLE, BEAT0, BEAT1; only IDLE drives st_ready=1.
REQ-017 Accepted legal request: IDLE->BEAT0; mem_req SHALL be high in the cycle after acceptance.
REQ-018 In BEAT0/BEAT1, mem_req, mem_addr, mem_wdata, mem_be SHALL be registered and stable until the edge where mem_ack=1.
REQ-019 k = st_addr[1:0]; A = st_addr with bits [1:0] cleared.
REQ-020 Byte: one beat; addr A; be = 0001<<k; wdata = data[7:0]<<8k.
REQ-021 Half, k<=2: one beat; addr A; be = 0011<<k; wdata = data[15:0]<<8k.
REQ-022 Half, k=3: two beats; beat0 addr A, be 1000, wdata[31:24]=data[7:0]; beat1 addr A+4, be 0001, wdata[7:0]=data[15:8].
REQ-023 Word, k=0: one beat; be 1111; wdata = data.
REQ-024 Word, k!=0: two beats; beat0 addr A, be = (1111<<k) truncated to 4 bits, wdata = data<<8k; beat1 addr A+4, be = 1111>>(4-k), wdata = data>>8(4-k).
REQ-025 A+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-026 Ack in BEAT0: split store -> BEAT1; otherwise -> IDLE.
REQ-027 Ack in BEAT1 -> IDLE.
REQ-028 done SHALL pulse for exactly one cycle, in the cycle after the final ack; st_ready SHALL be high in that same cycle.
REQ-029 mem_req SHALL be low in the cycle after the final ack; no gap cycle between BEAT0 ack and BEAT1 mem_req is permitted.
REQ-030 st_size=11 accepted in IDLE: no mem_req, err pulses one cycle next cycle, state stays IDLE.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 st_valid while st_ready=0 SHALL be ignored; requests are not queued.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, st_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, err=0.
REQ-034 Reset mid-transaction SHALL abandon the store with no done pulse; a pending beat is not completed.
REQ-035 The first acceptance SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-036 Shared package store_fmt_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL) and the state encoding.
REQ-037 Sub-module lane_shifter (combinational: data, size, k, beat index -> be, wdata, split flag) SHALL compute lane placement; store_formatter holds FSM and registers.

Verification
REQ-038 Byte, addr 0x00001002, data 0xAABBCC5A -> one beat addr 0x00001000, be 0100, wdata 0x005A0000; done one cycle after ack.
REQ-039 Half, addr 0x00002003, data 0x0000BEEF, ack immediately -> beat0 0x00002000 be 1000 wdata 0xEF000000; beat1 0x00002004 be 0001 wdata 0x000000BE.
REQ-040 Word, addr 0xFFFFFFFD, data 0x11223344, ack delayed 3 cycles each beat -> beat0 0xFFFFFFFC be 1110 wdata 0x22334400, outputs stable during wait; beat1 0x00000000 be 0001 wdata 0x00000011.
REQ-041 Size 11, any addr -> err pulse one cycle, mem_req stays 0, st_ready stays 1.
REQ-042 Word split, rst_n low during BEAT1 -> mem_req 0 immediately, no done pulse; a new request after reset completes normally.
REQ-043 Back-to-back stores with st_valid held high -> second accepted in the done cycle; no mem_req overlap.

Source files
------------

// File: rtl/store_fmt_pkg.sv
// Shared encodings for the store formatter: size codes, FSM states and the bus beat payload.
package store_fmt_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_beat_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// Combinational lane placement: positions store data and byte enables for either beat of a
// possibly word-crossing store.
module lane_shifter
  import store_fmt_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic [1:0]        k_i,
  input  logic              beat_i,
  output logic [BE_W-1:0]   be_c_o,
  output logic [DATA_W-1:0] wdata_c_o,
  output logic              split_c_o
);

  localparam int unsigned WIDE_W    = 2 * DATA_W;
  localparam int unsigned WIDE_BE_W = 2 * BE_W;

  logic [DATA_W-1:0]    masked;
  logic [BE_W-1:0]      base_be;
  logic [4:0]           sh;
  logic [WIDE_W-1:0]    wide_data;
  logic [WIDE_BE_W-1:0] wide_be;

  // Shift into a double-width window; the upper half is what spills into the next word.
  always_comb begin
    masked  = '0;
    base_be = '0;
    case (size_i)
      SZ_BYTE: begin
        masked  = DATA_W'(data_i[7:0]);
        base_be = BE_W'(4'b0001);
      end
      SZ_HALF: begin
        masked  = DATA_W'(data_i[15:0]);
        base_be = BE_W'(4'b0011);
      end
      SZ_WORD: begin
        masked  = data_i;
        base_be = BE_W'(4'b1111);
      end
      default: begin
        masked  = '0;
        base_be = '0;
      end
    endcase
    sh        = {k_i, 3'b000};
    wide_data = WIDE_W'(masked) << sh;
    wide_be   = WIDE_BE_W'(base_be) << k_i;
    split_c_o = |wide_be[WIDE_BE_W-1:BE_W];
    if (beat_i) begin
      be_c_o    = wide_be[WIDE_BE_W-1:BE_W];
      wdata_c_o = wide_data[WIDE_W-1:DATA_W];
    end else begin
      be_c_o    = wide_be[BE_W-1:0];
      wdata_c_o = wide_data[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/store_formatter.sv
// CPU store to word-bus formatter: accepts byte/half/word stores and issues one or two
// lane-positioned, word-aligned write beats.
module store_formatter
  import store_fmt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              split_q, split_d;
  mem_beat_t         beat_q, beat_d;
  logic              mem_req_q, mem_req_d;
  logic              st_ready_q, st_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] ls_data;
  logic [1:0]        ls_size;
  logic [1:0]        ls_k;
  logic              ls_beat;
  logic [BE_W-1:0]   ls_be;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_split;

  // In IDLE the shifter sees the incoming request (beat 0); otherwise the captured one (beat 1).
  always_comb begin
    ls_data = st_data;
    ls_size = st_size;
    ls_k    = st_addr[1:0];
    ls_beat = 1'b0;
    if (state_q != ST_IDLE) begin
      ls_data = data_q;
      ls_size = size_q;
      ls_k    = k_q;
      ls_beat = 1'b1;
    end
  end

  lane_shifter u_lane_shifter (
    .data_i    (ls_data),
    .size_i    (ls_size),
    .k_i       (ls_k),
    .beat_i    (ls_beat),
    .be_c_o    (ls_be),
    .wdata_c_o (ls_wdata),
    .split_c_o (ls_split)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    size_d     = size_q;
    k_d        = k_q;
    addr_d     = addr_q;
    split_d    = split_q;
    beat_d     = beat_q;
    mem_req_d  = mem_req_q;
    st_ready_d = st_ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (st_valid) begin
          if (st_size == SZ_ILL) begin
            err_d = 1'b1;
          end else begin
            data_d     = st_data;
            size_d     = st_size;
            k_d        = st_addr[1:0];
            addr_d     = word_align(st_addr);
            split_d    = ls_split;
            beat_d     = '{addr: word_align(st_addr), wdata: ls_wdata, be: ls_be};
            mem_req_d  = 1'b1;
            st_ready_d = 1'b0;
            state_d    = ST_BEAT0;
          end
        end
      end
      ST_BEAT0: begin
        if (mem_ack) begin
          if (split_q) begin
            beat_d  = '{addr: addr_q + ADDR_W'(4), wdata: ls_wdata, be: ls_be};
            state_d = ST_BEAT1;
          end else begin
            beat_d     = '0;
            mem_req_d  = 1'b0;
            st_ready_d = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_BEAT1: begin
        if (mem_ack) begin
          beat_d     = '0;
          mem_req_d  = 1'b0;
          st_ready_d = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        beat_d     = '0;
        mem_req_d  = 1'b0;
        st_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      size_q     <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      split_q    <= 1'b0;
      beat_q     <= '0;
      mem_req_q  <= 1'b0;
      st_ready_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      size_q     <= size_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      split_q    <= split_d;
      beat_q     <= beat_d;
      mem_req_q  <= mem_req_d;
      st_ready_q <= st_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign st_ready  = st_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = beat_q.addr;
  assign mem_wdata = beat_q.wdata;
  assign mem_be    = beat_q.be;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_formatter.sv
// Directed, table-driven bench for store_formatter plus hand-written reset/back-to-back sequences.
module tb_store_formatter;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  delay;
    logic [1:0]  nbeats;  // 0 means an illegal-size reject is expected
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[12];

  store_formatter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it through every beat, checking each cycle.
  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] ea;
    logic [3:0]  eb;
    logic [31:0] ed;
    st_valid = 1'b1;
    st_addr  = v.addr;
    st_data  = v.data;
    st_size  = v.size;
    chk($sformatf("v%0d ready_before", idx), 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    if (v.nbeats == 2'd0) begin
      chk($sformatf("v%0d err_pulse", idx), 32'(err), 32'd1);
      chk($sformatf("v%0d err_no_req", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d err_ready", idx), 32'(st_ready), 32'd1);
      tick();
      chk($sformatf("v%0d err_clear", idx), 32'(err), 32'd0);
      chk($sformatf("v%0d err_no_req2", idx), 32'(mem_req), 32'd0);
    end else begin
      for (int b = 0; b < int'(v.nbeats); b++) begin
        ea = (b == 0) ? v.a0 : v.a1;
        eb = (b == 0) ? v.be0 : v.be1;
        ed = (b == 0) ? v.d0 : v.d1;
        for (int w = 0; w <= int'(v.delay); w++) begin
          chk($sformatf("v%0d b%0d w%0d req", idx, b, w), 32'(mem_req), 32'd1);
          chk($sformatf("v%0d b%0d w%0d addr", idx, b, w), mem_addr, ea);
          chk($sformatf("v%0d b%0d w%0d be", idx, b, w), 32'(mem_be), 32'(eb));
          chk($sformatf("v%0d b%0d w%0d wdata", idx, b, w), mem_wdata, ed);
          chk($sformatf("v%0d b%0d w%0d ready", idx, b, w), 32'(st_ready), 32'd0);
          chk($sformatf("v%0d b%0d w%0d done", idx, b, w), 32'(done), 32'd0);
          chk($sformatf("v%0d b%0d w%0d err", idx, b, w), 32'(err), 32'd0);
          if (w < int'(v.delay)) tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
      end
      chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d done_req_low", idx), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d done_ready", idx), 32'(st_ready), 32'd1);
      tick();
      chk($sformatf("v%0d done_clear", idx), 32'(done), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h0000_1002, 32'hAABB_CC5A, 2'b00, 4'd0, 2'd1,
                 32'h0000_1000, 4'b0100, 32'h005A_0000, 32'h0, 4'b0000, 32'h0};
    vecs[1]  = '{32'h0000_2003, 32'h0000_BEEF, 2'b01, 4'd0, 2'd2,
                 32'h0000_2000, 4'b1000, 32'hEF00_0000, 32'h0000_2004, 4'b0001, 32'h0000_00BE};
    vecs[2]  = '{32'hFFFF_FFFD, 32'h1122_3344, 2'b10, 4'd3, 2'd2,
                 32'hFFFF_FFFC, 4'b1110, 32'h2233_4400, 32'h0000_0000, 4'b0001, 32'h0000_0011};
    vecs[3]  = '{32'h1234_5678, 32'hDEAD_BEEF, 2'b11, 4'd0, 2'd0,
                 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0};
    vecs[4]  = '{32'h0000_3000, 32'hDEAD_BEEF, 2'b10, 4'd1, 2'd1,
                 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'b0000, 32'h0};
    vecs[5]  = '{32'h4000_0006, 32'h1234_ABCD, 2'b01, 4'd0, 2'd1,
                 32'h4000_0004, 4'b1100, 32'hABCD_0000, 32'h0, 4'b0000, 32'h0};
    vecs[6]  = '{32'h0000_0007, 32'h0000_00FF, 2'b00, 4'd2, 2'd1,
                 32'h0000_0004, 4'b1000, 32'hFF00_0000, 32'h0, 4'b0000, 32'h0};
    vecs[7]  = '{32'h0000_100A, 32'hCAFE_F00D, 2'b10, 4'd1, 2'd2,
                 32'h0000_1008, 4'b1100, 32'hF00D_0000, 32'h0000_100C, 4'b0011, 32'h0000_CAFE};
    vecs[8]  = '{32'h0000_0203, 32'h89AB_CDEF, 2'b10, 4'd0, 2'd2,
                 32'h0000_0200, 4'b1000, 32'hEF00_0000, 32'h0000_0204, 4'b0111, 32'h0089_ABCD};
    vecs[9]  = '{32'h0000_0010, 32'hFFFF_1234, 2'b01, 4'd0, 2'd1,
                 32'h0000_0010, 4'b0011, 32'h0000_1234, 32'h0, 4'b0000, 32'h0};
    vecs[10] = '{32'h0000_0011, 32'h0000_5678, 2'b01, 4'd0, 2'd1,
                 32'h0000_0010, 4'b0110, 32'h0056_7800, 32'h0, 4'b0000, 32'h0};
    vecs[11] = '{32'h0000_0020, 32'h0000_0099, 2'b00, 4'd0, 2'd1,
                 32'h0000_0020, 4'b0001, 32'h0000_0099, 32'h0, 4'b0000, 32'h0};

    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = 2'b00;
    mem_ack  = 1'b0;

    #12;
    chk("rst ready", 32'(st_ready), 32'd1);
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    chk("rst be", 32'(mem_be), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Stray acks while idle must not start or finish anything.
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_ack%0d req", i), 32'(mem_req), 32'd0);
      chk($sformatf("idle_ack%0d done", i), 32'(done), 32'd0);
    end
    mem_ack = 1'b0;
    tick();

    // Requests arriving while busy are dropped, not queued.
    st_valid = 1'b1; st_addr = 32'h0000_0000; st_data = 32'h0000_0011; st_size = 2'b00;
    tick();
    st_addr = 32'h0000_0050; st_data = 32'h0000_0077;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d ready", i), 32'(st_ready), 32'd0);
      chk($sformatf("busy%0d addr", i), mem_addr, 32'h0000_0000);
      chk($sformatf("busy%0d wdata", i), mem_wdata, 32'h0000_0011);
      tick();
    end
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
    chk("busy done", 32'(done), 32'd1);
    tick();
    chk("busy not_queued", 32'(mem_req), 32'd0);
    tick();
    chk("busy not_queued2", 32'(mem_req), 32'd0);

    // Reset while the second beat of a split word is pending.
    st_valid = 1'b1; st_addr = 32'h0000_0001; st_data = 32'h1122_3344; st_size = 2'b10;
    tick();
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
    chk("rstmid beat1 req", 32'(mem_req), 32'd1);
    chk("rstmid beat1 addr", mem_addr, 32'h0000_0004);
    chk("rstmid beat1 be", 32'(mem_be), 32'h1);
    chk("rstmid beat1 wdata", mem_wdata, 32'h0000_0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid req", 32'(mem_req), 32'd0);
    chk("rstmid ready", 32'(st_ready), 32'd1);
    chk("rstmid be", 32'(mem_be), 32'd0);
    chk("rstmid done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstmid after%0d done", i), 32'(done), 32'd0);
      chk($sformatf("rstmid after%0d req", i), 32'(mem_req), 32'd0);
    end
    run_vec(100, vecs[2]);

    // Back-to-back with st_valid held: second store accepted in the done cycle.
    st_valid = 1'b1; st_addr = 32'h0000_0000; st_data = 32'h0000_00A1; st_size = 2'b00;
    tick();
    st_addr = 32'h0000_0008; st_data = 32'h0000_B2C3; st_size = 2'b01;
    chk("b2b first req", 32'(mem_req), 32'd1);
    chk("b2b first addr", mem_addr, 32'h0000_0000);
    chk("b2b first be", 32'(mem_be), 32'h1);
    chk("b2b first wdata", mem_wdata, 32'h0000_00A1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b done", 32'(done), 32'd1);
    chk("b2b done ready", 32'(st_ready), 32'd1);
    chk("b2b gap req", 32'(mem_req), 32'd0);
    tick();
    st_valid = 1'b0;
    chk("b2b second req", 32'(mem_req), 32'd1);
    chk("b2b second addr", mem_addr, 32'h0000_0008);
    chk("b2b second be", 32'(mem_be), 32'h3);
    chk("b2b second wdata", mem_wdata, 32'h0000_B2C3);
    chk("b2b second done_low", 32'(done), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b second end_req", 32'(mem_req), 32'd0);
    tick();
    chk("b2b idle req", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
